msg_streamer: RTL and testbench

Parametrised, software-loadable character streamer for the Tiny Tapeout display and pin-output path. Holds up to DEPTH characters in an internal buffer written through a simple write port, then plays a programmable-length message one character at a time over a valid/ready output with a programmable inter-character gap, in one-shot or loop mode. It sits between the input-switch/config logic and the uo_out driver, and supports start, stop, completion reporting and back-pressure.

---
 rtl/msg_streamer_if.sv | 9 +
 rtl/msg_streamer.sv | 148 ++++++++++++++
 tb/tb_msg_streamer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/msg_streamer_if.sv
// Character stream from msg_streamer towards the pin driver: data with valid/ready.
interface msg_streamer_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/msg_streamer.sv
// Buffered character streamer: plays cfg_len buffer entries over valid/ready with a gap.
// Define MSG_STREAM_EOM_EN to append EOM_CHAR as an extra beat after every pass.
module msg_streamer #(
   parameter int                DATA_W   = 8,
   parameter int                DEPTH    = 64,
   parameter int                DIV_W    = 16,
   parameter logic [DATA_W-1:0] EOM_CHAR = 8'h0A,
   localparam int               AW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [AW:0]       cfg_len_i,
   input  logic              cfg_loop_i,
   input  logic [DIV_W-1:0]  cfg_div_i,
   input  logic              start_i,
   input  logic              stop_i,
   output logic              busy_o,
   output logic              done_o,
   msg_streamer_if.master    so
);
`ifdef MSG_STREAM_EOM_EN
   localparam bit EOM_EN = 1'b1;
`else
   localparam bit EOM_EN = 1'b0;
`endif
   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, PRESENT, GAP} state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [AW:0]         len_q, len_d;
   logic                loop_q, loop_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic                eom_q, eom_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                done_q, done_d;
   logic                hs, last, fin;

   logic [DATA_W-1:0]   mem [DEPTH];

   assign hs   = out_valid_q & so.out_ready;
   assign last = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

   // Reads happen combinationally in LOAD and land in out_data_q, so a same-cycle write is not seen.
   always_ff @(posedge clk)
      if (wr_en_i && ({1'b0, wr_addr_i} < LEN_MAX)) mem[wr_addr_i] <= wr_data_i;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      loop_d      = loop_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      eom_d       = eom_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      fin         = 1'b0;
      if (stop_i) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         idx_d       = '0;
         cnt_d       = '0;
         eom_d       = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (start_i) begin
               if (cfg_len_i == '0) done_d = 1'b1;
               else begin
                  len_d   = (cfg_len_i > LEN_MAX) ? LEN_MAX : cfg_len_i;
                  loop_d  = cfg_loop_i;
                  div_d   = cfg_div_i;
                  idx_d   = '0;
                  eom_d   = 1'b0;
                  state_d = LOAD;
               end
            end
            LOAD: begin
               out_data_d  = eom_q ? EOM_CHAR : mem[idx_q];
               out_valid_d = 1'b1;
               state_d     = PRESENT;
            end
            PRESENT: if (hs) begin
               out_valid_d = 1'b0;
               if (!last)                 idx_d = idx_q + AW'(1);
               else if (EOM_EN && !eom_q) eom_d = 1'b1;
               else begin
                  eom_d = 1'b0;
                  idx_d = '0;
                  fin   = ~loop_q;
               end
               if (fin) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else if (div_q != '0) begin
                  state_d = GAP;
                  cnt_d   = div_q;
               end else state_d = LOAD;
            end
            GAP: begin
               if (cnt_q <= DIV_W'(1)) begin
                  state_d = LOAD;
                  cnt_d   = '0;
               end else cnt_d = cnt_q - DIV_W'(1);
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         loop_q      <= 1'b0;
         div_q       <= '0;
         cnt_q       <= '0;
         eom_q       <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         loop_q      <= loop_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         eom_q       <= eom_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign so.out_data  = out_data_q;
   assign so.out_valid = out_valid_q;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
endmodule

// File: tb/tb_msg_streamer.sv
// Bench for msg_streamer: beat-level reference model checked every cycle, directed and random traffic.
module tb_msg_streamer;
   localparam int DATA_W = 8, DEPTH = 64, DIV_W = 16, AW = $clog2(DEPTH);
   localparam logic [7:0] EOMC = 8'h0A;
`ifdef MSG_STREAM_EOM_EN
   localparam int EOMB = 1;
`else
   localparam int EOMB = 0;
`endif

   logic              clk = 1'b0, rst_n = 1'b0;
   logic              wr_en = 1'b0, start = 1'b0, stop = 1'b0, cfg_loop = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [AW:0]       cfg_len = '0;
   logic [DIV_W-1:0]  cfg_div = '0;
   logic              busy, done;

   msg_streamer_if #(.DATA_W(DATA_W)) sif ();

   msg_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W), .EOM_CHAR(EOMC)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .cfg_len_i(cfg_len), .cfg_loop_i(cfg_loop), .cfg_div_i(cfg_div), .start_i(start),
      .stop_i(stop), .busy_o(busy), .done_o(done), .so(sif.master));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Reference: each beat shows up div+2 cycles after the previous handshake (2 after start),
   // carrying the buffer value as it stood in the cycle before it appears.
   logic [7:0] mmem [DEPTH];
   bit         m_active = 0, m_done = 0, m_loop = 0, nd, exp_v;
   int         m_len = 0, m_div = 0, m_pos = 0, m_pres = 0;
   logic [7:0] m_data = '0;
   int         hs_cyc[$], done_cyc[$];
   logic [7:0] hs_dat[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         m_active = 0; m_done = 0; m_pos = 0;
         chk("rst_valid", sif.out_valid, 0);
         chk("rst_data", sif.out_data, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
      end else begin
         exp_v = m_active && (cyc >= m_pres);
         chk("busy", busy, m_active);
         chk("done", done, m_done);
         chk("valid", sif.out_valid, exp_v);
         if (exp_v) chk("data", sif.out_data, m_data);
         if (sif.out_valid && sif.out_ready) begin hs_cyc.push_back(cyc); hs_dat.push_back(sif.out_data); end
         if (done) done_cyc.push_back(cyc);
         nd = 0;
         if (stop) m_active = 0;
         else if (!m_active) begin
            if (start) begin
               if (cfg_len == 0) nd = 1;
               else begin
                  m_len = (cfg_len > DEPTH) ? DEPTH : int'(cfg_len);
                  m_loop = cfg_loop; m_div = int'(cfg_div);
                  m_pos = 0; m_pres = cyc + 2; m_active = 1;
               end
            end
         end else begin
            if (cyc == m_pres - 1) m_data = (m_pos < m_len) ? mmem[m_pos] : EOMC;
            if (exp_v && sif.out_ready) begin
               m_pos++;
               if (m_pos == m_len + EOMB) begin
                  if (m_loop) m_pos = 0;
                  else begin m_active = 0; nd = 1; end
               end
               m_pres = cyc + m_div + 2;
            end
         end
         m_done = nd;
         if (wr_en) mmem[wr_addr] = wr_data;
      end
   end

   task automatic step(); @(posedge clk); #1; endtask
   task automatic idle_in(); wr_en = 0; start = 0; stop = 0; endtask

   int t0;
   // One message started this cycle; stimulus events are relative cycle numbers (k = cyc - t0).
   task automatic run_msg(input int len, input bit lp, input int dv, input int stop_at,
                          input int wr_at, input int wa, input int wd, input int st_lo, input int st_hi);
      int k;
      hs_cyc.delete(); hs_dat.delete(); done_cyc.delete();
      cfg_len = (AW+1)'(len); cfg_loop = lp; cfg_div = DIV_W'(dv); sif.out_ready = 1;
      start = 1; t0 = cyc;
      for (k = 1; k < 3000; k++) begin
         step(); idle_in();
         if (k >= 2 && !busy && k > stop_at) break;
         sif.out_ready = !(k >= st_lo && k <= st_hi);
         if (k == wr_at) begin wr_en = 1; wr_addr = AW'(wa); wr_data = 8'(wd); end
         if (k == stop_at) stop = 1;
      end
      chk("run_timeout", busy, 0);
      step();
   endtask

   logic [7:0] hola [4];
   int len, lim;
   bit lp;

   initial begin : main
      hola = '{8'h48, 8'h6F, 8'h6C, 8'h61};
      sif.out_ready = 1;
      repeat (3) step();
      rst_n = 1;
      for (int a = 0; a < DEPTH; a++) begin
         wr_en = 1; wr_addr = AW'(a); wr_data = (a < 4) ? hola[a] : 8'($urandom); step();
      end
      idle_in(); step();

      // Hola one-shot, no gap
      run_msg(4, 0, 0, -1, -1, 0, 0, -1, -2);
      chk("t1_nbeats", hs_cyc.size(), 4 + EOMB);
      for (int b = 0; b < hs_cyc.size() && b < 4 + EOMB; b++) begin
         chk("t1_beat_cyc", hs_cyc[b] - t0, 2 + 2 * b);
         chk("t1_beat_data", hs_dat[b], (b < 4) ? hola[b] : EOMC);
      end
      chk("t1_done_cyc", (done_cyc.size() == 1) ? done_cyc[0] - t0 : -1, 9 + 2 * EOMB);

      // Loop with div 3, stopped at cycle 20
      run_msg(4, 1, 3, 20, -1, 0, 0, -1, -2);
      chk("t2_nbeats", hs_cyc.size(), 4);
      for (int b = 0; b < hs_cyc.size() && b < 4; b++) begin
         chk("t2_beat_cyc", hs_cyc[b] - t0, 2 + 5 * b);
         chk("t2_beat_data", hs_dat[b], hola[b]);
      end
      chk("t2_no_done", done_cyc.size(), 0);

      // Back-pressure on 2nd beat for 10 cycles
      run_msg(4, 0, 0, -1, -1, 0, 0, 4, 13);
      chk("t3_nbeats", hs_cyc.size(), 4 + EOMB);
      if (hs_cyc.size() >= 3) begin
         chk("t3_b1_cyc", hs_cyc[1] - t0, 14);
         chk("t3_b1_data", hs_dat[1], 8'h6F);
         chk("t3_b2_cyc", hs_cyc[2] - t0, 16);
         chk("t3_b2_data", hs_dat[2], 8'h6C);
      end

      // Zero length and over-length
      run_msg(0, 0, 0, -1, -1, 0, 0, -1, -2);
      chk("t4_zero_beats", hs_cyc.size(), 0);
      chk("t4_zero_done", (done_cyc.size() == 1) ? done_cyc[0] - t0 : -1, 1);
      run_msg(DEPTH + 5, 0, 0, -1, -1, 0, 0, -1, -2);
      chk("t4_clip_beats", hs_cyc.size(), DEPTH + EOMB);

      // Write during the gap before beat 2 is visible
      run_msg(4, 0, 3, -1, 4, 1, 8'h58, -1, -2);
      if (hs_cyc.size() >= 2) begin
         chk("t5_b1_cyc", hs_cyc[1] - t0, 7);
         chk("t5_b1_data", hs_dat[1], 8'h58);
      end else chk("t5_nbeats", hs_cyc.size(), 4 + EOMB);

      // Write to the address being loaded returns the old value
      run_msg(2, 0, 0, -1, 1, 0, 8'h99, -1, -2);
      chk("t6_nbeats", hs_cyc.size(), 2 + EOMB);
      if (hs_cyc.size() >= 1) chk("t6_b0_data", hs_dat[0], 8'h48);
      chk("t6_mem_new", mmem[0], 8'h99);

      // Asynchronous reset while a beat is presented
      cfg_len = 4; cfg_loop = 1; cfg_div = 0; start = 1; step(); idle_in();
      for (int k = 0; k < 10 && !sif.out_valid; k++) step();
      chk("t8_valid_before", sif.out_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("t8_async_valid", sif.out_valid, 0);
      chk("t8_async_data", sif.out_data, 0);
      chk("t8_async_busy", busy, 0);
      chk("t8_async_done", done, 0);
      step(); rst_n = 1; step();

      // Random traffic
      for (int m = 0; m < 40; m++) begin
         len = ($urandom_range(0, 7) == 0) ? DEPTH + 5 : $urandom_range(0, 12);
         lp = ($urandom_range(0, 3) == 0);
         cfg_len = (AW+1)'(len); cfg_loop = lp; cfg_div = DIV_W'($urandom_range(0, 4));
         start = 1; step(); idle_in();
         lim = lp ? $urandom_range(15, 60) : 4000;
         for (int k = 0; k < lim && (lp || busy); k++) begin
            sif.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 4) == 0) begin
               wr_en = 1; wr_addr = AW'($urandom_range(0, DEPTH - 1)); wr_data = 8'($urandom);
            end
            start = ($urandom_range(0, 19) == 0);
            stop = ($urandom_range(0, 199) == 0);
            step(); idle_in();
         end
         stop = 1; step(); idle_in(); step();
         chk("rand_idle", busy, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #600000;
      n_bad++;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
